// File: rtl/rtc_bus_responder.sv
// Responder end of the V3023-style RTC multiplexed bus: address/data phase decode,
// a 16 x 8-bit register file and a BCD seconds/minutes/hours chain driven by a prescaler.
module rtc_bus_responder #(
    parameter int TICK_DIV = 100000000,
    parameter int DIV_W    = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       AD,
    input  logic       CS,
    input  logic       RD,
    input  logic       WR,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       tick,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    state_t state;
    state_t state_next;

    logic       ad_q;
    logic       cs_q;
    logic       rd_q;
    logic       wr_q;
    logic [7:0] bus_q;

    logic       sel;
    logic       rd_act;
    logic       wr_act;
    logic       violation;
    logic       locked;

    logic [7:0] addr;
    logic [7:0] addr_shadow;
    logic [7:0] data_shadow;
    logic [7:0] regs [16];

    logic [DIV_W-1:0] presc;
    logic             tick_pending;

    logic addr_cap;
    logic data_cap;
    logic addr_commit;
    logic data_commit;
    logic read_latch;
    logic wr_hit;
    logic time_hit;
    logic apply_tick;

    logic [8:0] sec_inc;
    logic [8:0] min_inc;
    logic [8:0] hr_inc;

    // Returns {carry, next value}; non-BCD values fall through the same rules.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        logic [8:0] r;
        if (v >= lim) begin
            r = {1'b1, 8'h00};
        end else if (v[3:0] >= 4'd9) begin
            r = {1'b0, v[7:4] + 4'd1, 4'h0};
        end else begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // RD floats to deasserted unless it is a clean logic 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ad_q  <= 1'b1;
            cs_q  <= 1'b1;
            rd_q  <= 1'b1;
            wr_q  <= 1'b1;
            bus_q <= 8'h00;
        end else begin
            ad_q  <= AD;
            cs_q  <= CS;
            rd_q  <= (RD === 1'b0) ? 1'b0 : 1'b1;
            wr_q  <= WR;
            bus_q <= bus_in;
        end
    end

    assign sel       = (cs_q == 1'b0);
    assign rd_act    = (rd_q == 1'b0);
    assign wr_act    = (wr_q == 1'b0);
    assign violation = sel && rd_act && wr_act;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (violation) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sel && !locked) begin
                        if (!ad_q && wr_act) begin
                            state_next = ADDR;
                        end else if (ad_q && wr_act && !rd_act) begin
                            state_next = WDATA;
                        end else if (ad_q && rd_act && !wr_act) begin
                            state_next = RDATA;
                        end
                    end
                end
                ADDR:    if (!sel) state_next = IDLE;
                WDATA:   if (!sel) state_next = IDLE;
                RDATA:   if (!sel || !rd_act) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus_oe = 1'b0;
        if (state == RDATA && sel && rd_act && !wr_act) begin
            bus_oe = 1'b1;
        end
    end

    // After a violation, no new access is decoded until CS has been seen high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= violation && !locked;
            if (!sel) begin
                locked <= 1'b0;
            end else if (violation) begin
                locked <= 1'b1;
            end
        end
    end

    assign addr_cap    = (state_next == ADDR)  && wr_act;
    assign data_cap    = (state_next == WDATA) && wr_act;
    assign addr_commit = (state == ADDR)  && !sel;
    assign data_commit = (state == WDATA) && !sel;
    assign read_latch  = (state == IDLE)  && (state_next == RDATA);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr        <= 8'h00;
            addr_shadow <= 8'h00;
            data_shadow <= 8'h00;
            bus_out     <= 8'h00;
        end else begin
            if (addr_cap) begin
                addr_shadow <= bus_q;
            end
            if (data_cap) begin
                data_shadow <= bus_q;
            end
            if (addr_commit) begin
                addr <= addr_shadow;
            end
            if (read_latch) begin
                bus_out <= (addr < 8'h10) ? regs[addr[3:0]] : 8'h00;
            end
        end
    end

    assign tick = (presc == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A write to the time chain wins over a coincident tick; the tick is replayed next cycle.
    assign wr_hit     = data_commit && (addr < 8'h10);
    assign time_hit   = wr_hit && (addr[3:0] < 4'd3);
    assign apply_tick = (tick || tick_pending) && !time_hit;

    assign sec_inc = bcd_inc(regs[0], 8'h59);
    assign min_inc = bcd_inc(regs[1], 8'h59);
    assign hr_inc  = bcd_inc(regs[2], 8'h23);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_pending <= 1'b0;
        end else begin
            tick_pending <= (tick || tick_pending) && time_hit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            if (apply_tick) begin
                regs[0] <= sec_inc[7:0];
                if (sec_inc[8]) begin
                    regs[1] <= min_inc[7:0];
                end
                if (sec_inc[8] && min_inc[8]) begin
                    regs[2] <= hr_inc[7:0];
                end
            end
            if (wr_hit) begin
                regs[addr[3:0]] <= data_shadow;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with a 4-cycle tick so timekeeping can be
// exercised cycle-exactly alongside bus accesses.
module tb_rtc_bus_responder;

    localparam int TICK_DIV = 4;
    localparam int DIV_W    = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       AD = 1'b1;
    logic       CS = 1'b1;
    logic       RD = 1'b1;
    logic       WR = 1'b1;
    logic [7:0] bus_in = 8'h00;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       tick;
    logic       err;

    int checks = 0;
    int passed = 0;

    rtc_bus_responder #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset), .AD(AD), .CS(CS), .RD(RD), .WR(WR),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .tick(tick), .err(err)
    );

    always #5 clk = ~clk;

    // Each helper starts and ends on a falling edge; inputs change only there.
    task automatic drive_access(input logic ad, input logic [7:0] val);
        CS = 1'b0; AD = ad; WR = 1'b0; bus_in = val;
        @(negedge clk);
        CS = 1'b1; WR = 1'b1; AD = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_read(output logic oe1, output logic oe2, output logic [7:0] data,
                           output logic oe3);
        CS = 1'b0; AD = 1'b1; RD = 1'b0;
        @(negedge clk);
        oe1 = bus_oe;
        @(negedge clk);
        oe2 = bus_oe;
        data = bus_out;
        CS = 1'b1; RD = 1'b1;
        @(negedge clk);
        oe3 = bus_oe;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sync_tick(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tick === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic o1, o2, o3;
        logic [7:0] d;
        checks++; if (bus_oe !== 1'b0) $display("[TB] FAIL reset_oe: got %b want 0", bus_oe); else passed++;
        checks++; if (bus_out !== 8'h00) $display("[TB] FAIL reset_out: got %h want 00", bus_out); else passed++;
        checks++; if (tick !== 1'b0) $display("[TB] FAIL reset_tick: got %b want 0", tick); else passed++;
        checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", err); else passed++;
        reset = 1'b0;
        idle(1);
        drive_access(1'b0, 8'h03);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h00) $display("[TB] FAIL reset_reg3: got %h want 00", d); else passed++;
    endtask

    task automatic test_basic_rw();
        logic o1, o2, o3;
        logic [7:0] d;
        drive_access(1'b0, 8'h05);
        drive_access(1'b1, 8'hA7);
        do_read(o1, o2, d, o3);
        checks++; if (o1 !== 1'b0) $display("[TB] FAIL rd_latency_early: got %b want 0", o1); else passed++;
        checks++; if (o2 !== 1'b1) $display("[TB] FAIL rd_latency_oe: got %b want 1", o2); else passed++;
        checks++; if (d !== 8'hA7) $display("[TB] FAIL rd_data_reg5: got %h want a7", d); else passed++;
        checks++; if (o3 !== 1'b0) $display("[TB] FAIL rd_oe_drop: got %b want 0", o3); else passed++;
        checks++; if (bus_out !== 8'hA7) $display("[TB] FAIL rd_out_hold: got %h want a7", bus_out); else passed++;
        drive_access(1'b0, 8'h0F);
        drive_access(1'b1, 8'h3C);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h3C) $display("[TB] FAIL rd_data_reg15: got %h want 3c", d); else passed++;
    endtask

    task automatic test_back_to_back();
        logic o1, o2, o3;
        logic [7:0] d;
        drive_access(1'b0, 8'h03);
        drive_access(1'b1, 8'h11);
        drive_access(1'b0, 8'h04);
        drive_access(1'b1, 8'h22);
        drive_access(1'b0, 8'h03);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h11) $display("[TB] FAIL b2b_reg3: got %h want 11", d); else passed++;
        drive_access(1'b0, 8'h04);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h22) $display("[TB] FAIL b2b_reg4: got %h want 22", d); else passed++;
        checks++; if (o2 !== 1'b1) $display("[TB] FAIL b2b_oe: got %b want 1", o2); else passed++;
    endtask

    task automatic test_out_of_range();
        logic o1, o2, o3;
        logic [7:0] d;
        drive_access(1'b0, 8'h1F);
        drive_access(1'b1, 8'h55);
        do_read(o1, o2, d, o3);
        checks++; if (o2 !== 1'b1) $display("[TB] FAIL oor_oe: got %b want 1", o2); else passed++;
        checks++; if (d !== 8'h00) $display("[TB] FAIL oor_data: got %h want 00", d); else passed++;
        drive_access(1'b0, 8'h0F);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h3C) $display("[TB] FAIL oor_reg15_kept: got %h want 3c", d); else passed++;
        drive_access(1'b0, 8'h05);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'hA7) $display("[TB] FAIL oor_reg5_kept: got %h want a7", d); else passed++;
    endtask

    task automatic test_tick_period();
        bit ok;
        sync_tick(ok);
        checks++; if (ok !== 1'b1) $display("[TB] FAIL tick_seen: got %b want 1", ok); else passed++;
        idle(1);
        checks++; if (tick !== 1'b0) $display("[TB] FAIL tick_width: got %b want 0", tick); else passed++;
        idle(3);
        checks++; if (tick !== 1'b1) $display("[TB] FAIL tick_period: got %b want 1", tick); else passed++;
    endtask

    // Ticks land on the 1st, 5th, 9th ... rising edge after the sync point.
    task automatic test_bcd_carry();
        logic o1, o2, o3;
        logic [7:0] d;
        bit ok;
        sync_tick(ok);
        checks++; if (ok !== 1'b1) $display("[TB] FAIL carry_sync: got %b want 1", ok); else passed++;
        idle(1);
        drive_access(1'b0, 8'h00);
        drive_access(1'b1, 8'h00);
        drive_access(1'b0, 8'h01);
        drive_access(1'b1, 8'h00);
        drive_access(1'b0, 8'h00);
        drive_access(1'b1, 8'h58);
        idle(3);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h59) $display("[TB] FAIL carry_one_tick: got %h want 59", d); else passed++;
        idle(1);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h00) $display("[TB] FAIL carry_sec_wrap: got %h want 00", d); else passed++;
        drive_access(1'b0, 8'h01);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h01) $display("[TB] FAIL carry_min: got %h want 01", d); else passed++;
    endtask

    task automatic test_full_wrap();
        logic o1, o2, o3;
        logic [7:0] d;
        bit ok;
        sync_tick(ok);
        checks++; if (ok !== 1'b1) $display("[TB] FAIL wrap_sync: got %b want 1", ok); else passed++;
        idle(1);
        drive_access(1'b0, 8'h00);
        drive_access(1'b1, 8'h00);
        drive_access(1'b0, 8'h02);
        drive_access(1'b1, 8'h23);
        drive_access(1'b0, 8'h01);
        drive_access(1'b1, 8'h59);
        drive_access(1'b0, 8'h00);
        drive_access(1'b1, 8'h59);
        idle(3);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h00) $display("[TB] FAIL wrap_sec: got %h want 00", d); else passed++;
        drive_access(1'b0, 8'h01);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h00) $display("[TB] FAIL wrap_min: got %h want 00", d); else passed++;
        drive_access(1'b0, 8'h02);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h00) $display("[TB] FAIL wrap_hour: got %h want 00", d); else passed++;
    endtask

    task automatic test_tick_collision();
        logic o1, o2, o3;
        logic [7:0] d;
        bit ok;
        sync_tick(ok);
        checks++; if (ok !== 1'b1) $display("[TB] FAIL coll_sync: got %b want 1", ok); else passed++;
        drive_access(1'b0, 8'h00);
        drive_access(1'b1, 8'h30);
        idle(1);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h31) $display("[TB] FAIL coll_pending: got %h want 31", d); else passed++;
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h32) $display("[TB] FAIL coll_next_tick: got %h want 32", d); else passed++;
    endtask

    task automatic test_violation();
        logic o1, o2, o3;
        logic [7:0] d;
        drive_access(1'b0, 8'h05);
        CS = 1'b0; AD = 1'b1; RD = 1'b0; WR = 1'b0; bus_in = 8'h99;
        idle(1);
        checks++; if (err !== 1'b0) $display("[TB] FAIL viol_err_early: got %b want 0", err); else passed++;
        idle(1);
        checks++; if (err !== 1'b1) $display("[TB] FAIL viol_err_pulse: got %b want 1", err); else passed++;
        checks++; if (bus_oe !== 1'b0) $display("[TB] FAIL viol_oe: got %b want 0", bus_oe); else passed++;
        WR = 1'b1;
        idle(1);
        checks++; if (err !== 1'b0) $display("[TB] FAIL viol_err_width: got %b want 0", err); else passed++;
        idle(1);
        checks++; if (bus_oe !== 1'b0) $display("[TB] FAIL viol_locked_a: got %b want 0", bus_oe); else passed++;
        idle(1);
        checks++; if (bus_oe !== 1'b0) $display("[TB] FAIL viol_locked_b: got %b want 0", bus_oe); else passed++;
        CS = 1'b1; RD = 1'b1;
        idle(1);
        do_read(o1, o2, d, o3);
        checks++; if (o2 !== 1'b1) $display("[TB] FAIL viol_recover_oe: got %b want 1", o2); else passed++;
        checks++; if (d !== 8'hA7) $display("[TB] FAIL viol_reg5_kept: got %h want a7", d); else passed++;
    endtask

    task automatic test_reset_mid_read();
        logic o1, o2, o3;
        logic [7:0] d;
        CS = 1'b0; AD = 1'b1; RD = 1'b0;
        idle(2);
        checks++; if (bus_oe !== 1'b1) $display("[TB] FAIL mid_oe_before: got %b want 1", bus_oe); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (bus_oe !== 1'b0) $display("[TB] FAIL mid_oe_drop: got %b want 0", bus_oe); else passed++;
        checks++; if (bus_out !== 8'h00) $display("[TB] FAIL mid_out_clear: got %h want 00", bus_out); else passed++;
        @(negedge clk);
        CS = 1'b1; RD = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        drive_access(1'b0, 8'h05);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h00) $display("[TB] FAIL mid_reg5_clear: got %h want 00", d); else passed++;
        drive_access(1'b0, 8'h0F);
        do_read(o1, o2, d, o3);
        checks++; if (d !== 8'h00) $display("[TB] FAIL mid_reg15_clear: got %h want 00", d); else passed++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_basic_rw();
        test_back_to_back();
        test_out_of_range();
        test_tick_period();
        test_bcd_carry();
        test_full_wrap();
        test_tick_collision();
        test_violation();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rtc_bus_responder.md
Name: rtc_bus_responder

Overview:
- Bus-side model of the V3023-style real-time clock: the responder end of the multiplexed address/data bus driven by the FPGA RTC controller (active-low AD, CS, RD, WR).
- Decodes address and data phases, holds a 16 x 8-bit register file and advances BCD seconds/minutes/hours from a clock prescaler.
- Used as the synthesizable RTC stand-in for board bring-up and as the self-checking target in controller benches.

Parameters:
- TICK_DIV, 100000000, clk cycles per timekeeping tick (1 s at 100 MHz); must be >= 2.
- DIV_W, 27, width of the prescaler counter; must satisfy 2^DIV_W > TICK_DIV.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high; all state cleared while high
- AD  in  1  active-low address/data select (0 = address phase)
- CS  in  1  active-low chip select
- RD  in  1  active-low read strobe; X/Z are treated as deasserted (pull-up semantics)
- WR  in  1  active-low write strobe
- bus_in  in  8  multiplexed address/data from the bus
- bus_out  out  8  read data toward the bus
- bus_oe  out  1  drive enable for bus_out; the top level builds the tristate
- tick  out  1  one-cycle pulse on each prescaler rollover
- err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset values: bus_out=0x00, bus_oe=0, tick=0, err=0, state=IDLE, addr=0x00, prescaler=0, all 16 registers=0x00, tick_pending=0.
- Inputs are synchronous to clk and pass through one register stage (AD_q, CS_q, RD_q, WR_q, bus_q). All decisions use the registered copies.
- Strobe assertion: a strobe counts as asserted only when its registered value is logic 0.
- FSM states: IDLE, ADDR, WDATA, RDATA.
- IDLE transitions, evaluated when CS_q=0:
  - AD_q=0 and WR_q=0 -> ADDR.
  - AD_q=1 and WR_q=0 and RD_q deasserted -> WDATA.
  - AD_q=1 and RD_q=0 and WR_q=1 -> RDATA.
  - Otherwise stay in IDLE.
- Protocol violation: CS_q=0 with RD_q=0 and WR_q=0 in any state. Pulse err, force the FSM to IDLE, drop bus_oe and commit nothing. The FSM then waits for CS_q=1 before it will decode a new access.
- ADDR:
  - Capture bus_q into the address shadow every cycle while CS_q=0 and WR_q=0.
  - On CS_q returning to 1, commit the shadow to addr and go to IDLE. The last sampled value wins.
- WDATA:
  - Capture bus_q into the data shadow every cycle while CS_q=0 and WR_q=0.
  - On CS_q returning to 1, write the shadow to reg[addr[3:0]] if addr < 0x10, then go to IDLE.
  - If addr >= 0x10 the write is discarded.
- RDATA:
  - In the first cycle after entry, latch bus_out <= reg[addr[3:0]], or 0x00 if addr >= 0x10, and set bus_oe=1.
  - Latency is 2 clk from the raw RD falling edge to bus_oe=1.
  - bus_out holds the latched value for the whole strobe, even if a tick updates the register meanwhile.
  - When CS_q=1 or RD_q deasserted: bus_oe=0, go to IDLE. bus_out keeps its last value.
- Back-to-back accesses: a new access is decoded on the first cycle CS_q=0 after returning to IDLE. No dead cycles are required beyond the CS high pulse.
- Register map:
  - reg0 = seconds BCD
  - reg1 = minutes BCD
  - reg2 = hours BCD, 24-hour
  - reg3..reg15 = general scratch, read/write, never modified by hardware
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick pulses for one cycle in the wrap cycle.
- Tick application:
  - A tick applies to the time chain in the same cycle, unless a bus write commits to reg0..reg2 in that cycle.
  - On such a collision, the write wins and the tick is held in tick_pending, then applied the following cycle to the post-write values.
- BCD increment, applied per field with limit L (0x59 for seconds and minutes, 0x23 for hours):
  - If value >= L: wrap to 0x00 and carry to the next field.
  - Else if low nibble >= 9: low nibble = 0, high nibble + 1.
  - Else: low nibble + 1.
  - Carry ripples within the same cycle. An hours wrap produces no further carry.
  - Non-BCD written values are stored as-is and follow these same rules.
- Reset mid-operation (asynchronous): any in-flight access is abandoned, bus_oe drops immediately, and registers return to 0x00.

Test Plan:
- Address 0x05, then write 0xA7, then read address 0x05 -> bus_oe rises 2 clk after RD low; bus_out=0xA7 while RD low; bus_oe=0 one cycle after CS high.
- Write 0x58 to reg0 with TICK_DIV=4 -> after 1 tick reg0=0x59; after 2 ticks reg0=0x00 and reg1=0x01.
- Preload reg0=0x59, reg1=0x59, reg2=0x23, then one tick -> reg0, reg1 and reg2 all read 0x00.
- Write reg0=0x30 committing in the exact tick cycle -> reg0=0x31 one cycle later (pending tick applied); no tick is lost.
- Address 0x1F, then write 0x55, then read 0x1F -> read returns 0x00; reg0..reg15 are unchanged.
- CS=0 with RD=0 and WR=0 -> err pulses one cycle, bus_oe stays 0, no register changes. Asserting reset mid-read -> bus_oe=0 immediately and all registers read 0x00 after release.
